ncl_dual_rail_rx: RTL
=====================

Name: ncl_dual_rail_rx

Overview:
Receiving end of the dual-rail NCL datapath. It collects DATA/NULL wavefronts from an NCL pipeline stage, such as the 3x3 multiplier product, into the synchronous domain. It performs completion detection, drives the NCL acknowledge (ko), and presents the decoded single-rail word on a valid/ready interface. Together with the NCL stage, it closes the four-phase DATA→NULL loop.

Parameters:
WIDTH, 6, number of dual-rail bits (3x3 product)
SYNC_STAGES, 2, flop stages per rail in the input synchronizer (≥2)
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
din_rail1  in  WIDTH  dual-rail data, rail1 of each bit
din_rail0  in  WIDTH  dual-rail data, rail0 of each bit
ko  out  1  NCL acknowledge: 1 = request-for-data, 0 = request-for-null
out_data  out  WIDTH  decoded single-rail word
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  consumer accepts out_data
err  out  1  sticky: illegal code (both rails high) seen on any bit
timeout  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (async, active-high): ko=1, out_valid=0, out_data=0, err=0, timeout=0, synchronizer and prev-sample regs cleared, FSM=WAIT_DATA.
- Both rails pass through SYNC_STAGES flops giving sample s. Register s_prev <= s every cycle.
- Per-bit decode of s: DATA0=01, DATA1=10, NULL=00, ILLEGAL=11.
  - complete = every bit DATA0/DATA1.
  - all_null = every bit NULL.
  - stable = (s == s_prev).
- ILLEGAL on any bit of s sets err (held until rst). That bit counts as neither DATA nor NULL, so the wavefront cannot complete.
- FSM:
  - WAIT_DATA (ko=1): if complete && stable && (!out_valid || out_ready), then out_data <= s.rail1, out_valid <= 1, ko <= 0, go to WAIT_NULL. If complete && stable but the buffer is full, stay and keep ko=1. Partial or mixed data means stay.
  - WAIT_NULL (ko=0): if all_null && stable, then ko <= 1 and go to WAIT_DATA. Anything else means stay.
- Output buffer is single-entry. A transfer occurs on out_valid && out_ready, which clears out_valid unless a capture happens in the same cycle. Simultaneous drain and capture leaves out_valid=1 with the new word.
- Latency: from din settling before edge N, capture (out_valid=1, ko=0) is visible after edge N+SYNC_STAGES+1, which is 4 edges by default. The NULL→ko=1 path has the same latency.
- No capture is possible in WAIT_NULL, so each DATA wavefront yields exactly one word.
- Reset mid-wavefront discards any partial or held word. After release, ko=1 and the next complete DATA is captured normally.

Optional Feature:
NCL_RX_TIMEOUT_EN
- Defined: a counter increments every cycle the FSM stays in the same state with ko unchanged and the buffer not stalled. It clears on each state change. Reaching TIMEOUT_CYCLES sets timeout (sticky until rst). FSM behaviour is unchanged.
- Undefined: no counter is built; timeout is tied to 0.

Decomposition:
- Package ncl_pkg holds:
  - the dual_rail_logic struct (rail1, rail0)
  - the rx_state_t enum {WAIT_DATA, WAIT_NULL}
  - functions dr_is_complete, dr_is_null, dr_is_illegal
  - the encodings DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10
- Sub-module ncl_rail_sync: a parameterized SYNC_STAGES-deep flop chain with async reset, instantiated once over the packed {rail1, rail0} bus.

Test Plan:
1. Basic DATA capture: rail1=101101, rail0=010010 held with out_ready=1 → out_valid=1 and out_data=6'h2D after 4 edges, ko=0. Then drive NULL → ko=1 4 edges later, and a single word is delivered.
2. Backpressure: out_ready=0. Capture 6'h2D, NULL, then DATA 6'h12 → ko stays 1 and 6'h12 is not captured. Raise out_ready → 6'h2D is consumed, and 6'h12 is captured the cycle it drains (out_valid stays 1).
3. Partial wavefront: bits set one per cycle over 6 cycles → no capture until the final bit has been stable 1 cycle. Then out_data is correct and ko=0.
4. Illegal code: bit 3 driven 11 with the other bits valid → err=1, no capture, ko stays 1. Correct bit 3 → capture proceeds and err remains 1.
5. Reset mid-operation: assert rst while in WAIT_NULL with out_valid=1 → immediately ko=1, out_valid=0, out_data=0, err=0. Afterwards, DATA 6'h3F is captured normally.
6. (NCL_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16) Capture DATA and never return to NULL → timeout=1 after 16 cycles while ko stays 0. Without the macro, timeout stays 0.

Source files
------------

// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - dual-rail NCL types, code points and per-bit decode helpers
package ncl_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  typedef enum logic [0:0] {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } rx_state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  function automatic logic dr_is_complete(input dual_rail_logic b);
    return (b == DR_0) || (b == DR_1);
  endfunction

  function automatic logic dr_is_null(input dual_rail_logic b);
    return b == DR_NULL;
  endfunction

  function automatic logic dr_is_illegal(input dual_rail_logic b);
    return b.rail1 && b.rail0;
  endfunction

endpackage

// File: rtl/ncl_rail_sync.sv
// rtl/ncl_rail_sync.sv - STAGES-deep flop chain bringing async rails into clk domain
module ncl_rail_sync #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/ncl_dual_rail_rx.sv
// rtl/ncl_dual_rail_rx.sv - NCL dual-rail receiver: completion detect, ko handshake, valid/ready output
// Optional watchdog built only when NCL_RX_TIMEOUT_EN is defined.
module ncl_dual_rail_rx
  import ncl_pkg::*;
#(
  parameter int WIDTH          = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_rail1,
  input  logic [WIDTH-1:0] din_rail0,
  output logic             ko,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             timeout
);

  logic [2*WIDTH-1:0] s_bus;
  logic [2*WIDTH-1:0] s_prev;
  logic [WIDTH-1:0]   bit_data;
  logic [WIDTH-1:0]   bit_null;
  logic [WIDTH-1:0]   bit_ill;
  logic               complete;
  logic               all_null;
  logic               illegal;
  logic               stable;
  logic               capture;
  logic               null_done;
  rx_state_t          state;

  ncl_rail_sync #(
    .WIDTH (2*WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din ({din_rail1, din_rail0}),
    .dout(s_bus)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dual_rail_logic b;
    assign b           = {s_bus[WIDTH+i], s_bus[i]};
    assign bit_data[i] = dr_is_complete(b);
    assign bit_null[i] = dr_is_null(b);
    assign bit_ill[i]  = dr_is_illegal(b);
  end

  assign complete = &bit_data;
  assign all_null = &bit_null;
  assign illegal  = |bit_ill;
  assign stable   = (s_bus == s_prev);

  // Capture may coincide with a drain, so the buffer only has to be free by the end of this cycle.
  assign capture   = (state == WAIT_DATA) && complete && stable && (!out_valid || out_ready);
  assign null_done = (state == WAIT_NULL) && all_null && stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev    <= '0;
      state     <= WAIT_DATA;
      ko        <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      s_prev <= s_bus;
      if (illegal) err <= 1'b1;
      if (capture) begin
        out_data  <= s_bus[2*WIDTH-1:WIDTH];
        out_valid <= 1'b1;
        ko        <= 1'b0;
        state     <= WAIT_NULL;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (null_done) begin
          ko    <= 1'b1;
          state <= WAIT_DATA;
        end
      end
    end
  end

`ifdef NCL_RX_TIMEOUT_EN
  localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wd_cnt;
  logic          wd_flag;

  // A stalled consumer is not the NCL side's fault, so the watchdog pauses then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (capture || null_done) begin
      wd_cnt <= '0;
    end else if (!(out_valid && !out_ready) && (wd_cnt != TO_MAX)) begin
      wd_cnt <= wd_cnt + CW'(1);
      if (wd_cnt + CW'(1) == TO_MAX) wd_flag <= 1'b1;
    end
  end

  assign timeout = wd_flag;
`else
  assign timeout = 1'b0;
`endif

endmodule
